// File: rtl/fp_pkg.sv
// Shared constants, classification types and helpers for the floating-point units.
package fp_pkg;

    // Operand classification produced by fp_unpack.
    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Early special-value decision carried down the multiplier pipeline.
    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_NAN,
        SPC_INF,
        SPC_ZERO
    } fp_special_e;

    // Exception flag vector layout: {invalid, overflow, underflow, inexact, zero_res}.
    localparam int unsigned FLAG_W         = 5;
    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_OVERFLOW  = 3;
    localparam int unsigned FLAG_UNDERFLOW = 2;
    localparam int unsigned FLAG_INEXACT   = 1;
    localparam int unsigned FLAG_ZERO      = 0;

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_ones(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = (64'(exp_ones(exp_w)) << man_w) | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand-issue and result handshake bundle for the pipelined multiplier.
interface fp_mul_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   in_a;
    logic [EXP_W+MAN_W:0]   in_b;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic [TAG_W-1:0]       out_tag;
    logic [FLAG_W-1:0]      out_flags;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_flags
    );
endinterface

// File: rtl/fp_unpack.sv
// Splits one IEEE-754 operand into fields, classifies it and inserts the hidden bit.
// Subnormals are flushed to zero on input.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 sign,
    output logic [EXP_W-1:0]     biased_exp,
    output logic [MAN_W:0]       man,
    output fp_class_e            cls
);
    logic [MAN_W-1:0] frac;

    // Field extraction and classification.
    always_comb begin
        sign       = op[EXP_W+MAN_W];
        biased_exp = op[EXP_W+MAN_W-1:MAN_W];
        frac       = op[MAN_W-1:0];
        cls        = CLS_NORM;
        man        = {1'b1, frac};
        if (biased_exp == '0) begin
            cls = CLS_ZERO;
            man = '0;
        end else if (biased_exp == '1) begin
            cls = (frac != '0) ? CLS_NAN : CLS_INF;
        end
    end
endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier: S1 unpack/classify/exponent, S2 mantissa
// product, S3 normalise/round/pack. A single global advance stalls every stage
// together while the output register is held.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           rst,
    fp_mul_pipe_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS_S = XW'(exp_bias(EXP_W));
    localparam logic signed [XW-1:0] ONES_S = XW'(exp_ones(EXP_W));
    localparam logic [W-1:0]         QNAN   = W'(canon_nan(EXP_W, MAN_W));

    logic advance;

    // S1 combinational
    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W:0]         ma, mb;
    fp_class_e              ca, cb;
    fp_special_e            spc_d;
    logic                   inv_d;
    logic signed [XW-1:0]   exp_d;

    // S1 registers
    logic                   v1;
    logic                   s1_sign;
    logic signed [XW-1:0]   s1_exp;
    logic [MAN_W:0]         s1_ma, s1_mb;
    fp_special_e            s1_spc;
    logic                   s1_inv;
    logic [TAG_W-1:0]       s1_tag;

    // S2 registers
    logic                   v2;
    logic                   s2_sign;
    logic signed [XW-1:0]   s2_exp;
    logic [PW-1:0]          s2_prod;
    fp_special_e            s2_spc;
    logic                   s2_inv;
    logic [TAG_W-1:0]       s2_tag;

    // S3 combinational
    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       frac;
    logic                   g, r, st, rnd_up;
    logic [MAN_W:0]         frac_r;
    logic signed [XW-1:0]   exp_f;
    logic [W-1:0]           res_d;
    logic [FLAG_W-1:0]      flags_d;

    // Output registers (S3)
    logic                   out_valid_q;
    logic [W-1:0]           out_result_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic [FLAG_W-1:0]      out_flags_q;

    assign advance        = !out_valid_q || bus.out_ready;
    assign bus.in_ready   = advance;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_flags  = out_flags_q;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op(bus.in_a), .sign(sa), .biased_exp(ea), .man(ma), .cls(ca)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op(bus.in_b), .sign(sb), .biased_exp(eb), .man(mb), .cls(cb)
    );

    // S1: special-value priority and unbiased exponent sum.
    always_comb begin
        spc_d = SPC_NONE;
        inv_d = 1'b0;
        exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
        if (ca == CLS_NAN || cb == CLS_NAN) begin
            spc_d = SPC_NAN;
        end else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
            spc_d = SPC_NAN;
            inv_d = 1'b1;
        end else if (ca == CLS_INF || cb == CLS_INF) begin
            spc_d = SPC_INF;
        end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
            spc_d = SPC_ZERO;
        end
    end

    // S1 register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_ma   <= '0;
            s1_mb   <= '0;
            s1_spc  <= SPC_NONE;
            s1_inv  <= 1'b0;
            s1_tag  <= '0;
        end else if (advance) begin
            v1      <= bus.in_valid;
            s1_sign <= sa ^ sb;
            s1_exp  <= exp_d;
            s1_ma   <= ma;
            s1_mb   <= mb;
            s1_spc  <= spc_d;
            s1_inv  <= inv_d;
            s1_tag  <= bus.in_tag;
        end
    end

    // S2 register stage: full-width mantissa product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_prod <= '0;
            s2_spc  <= SPC_NONE;
            s2_inv  <= 1'b0;
            s2_tag  <= '0;
        end else if (advance) begin
            v2      <= v1;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= PW'(s1_ma) * PW'(s1_mb);
            s2_spc  <= s1_spc;
            s2_inv  <= s1_inv;
            s2_tag  <= s1_tag;
        end
    end

    // S3: normalise so the leading one sits above the fraction, RNE round,
    // fold the rounding carry into the exponent, then range-check and pack.
    always_comb begin
        norm    = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        frac    = norm[PW-2 -: MAN_W];
        g       = norm[MAN_W];
        r       = norm[MAN_W-1];
        st      = |norm[MAN_W-2:0];
        rnd_up  = g & (r | st | frac[0]);
        frac_r  = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        exp_f   = s2_exp
                + $signed({{(XW-1){1'b0}}, s2_prod[PW-1]})
                + $signed({{(XW-1){1'b0}}, frac_r[MAN_W]});
        res_d   = '0;
        flags_d = '0;
        case (s2_spc)
            SPC_NAN: begin
                res_d = QNAN;
                flags_d[FLAG_INVALID] = s2_inv;
            end
            SPC_INF: begin
                res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            SPC_ZERO: begin
                res_d = {s2_sign, {(W-1){1'b0}}};
                flags_d[FLAG_ZERO] = 1'b1;
            end
            default: begin
                if (exp_f >= ONES_S) begin
                    res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d[FLAG_OVERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]  = 1'b1;
                end else if (exp_f[XW-1] || exp_f == '0) begin
                    res_d = {s2_sign, {(W-1){1'b0}}};
                    flags_d[FLAG_UNDERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]   = 1'b1;
                    flags_d[FLAG_ZERO]      = 1'b1;
                end else begin
                    res_d = {s2_sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
                    flags_d[FLAG_INEXACT] = g | r | st;
                end
            end
        endcase
    end

    // Output register: payload loads only with a real result so it holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_flags_q  <= '0;
        end else if (advance) begin
            out_valid_q <= v2;
            if (v2) begin
                out_result_q <= res_d;
                out_tag_q    <= s2_tag;
                out_flags_q  <= flags_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (single precision): scoreboard against a
// value-level reference multiplier, directed vectors, backpressure and reset.
module tb_fp_mul_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  t;
        logic [4:0]  f;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Reference: exact integer product, rounded to 24 significant bits (RNE).
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [4:0] fl);
        int ea, eb, k, sh, e;
        longint unsigned p, q, rem, half;
        logic s, za, zb, ia, ib, na, nb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (ia && zb) || (za && ib)) begin
            res = 32'h7FC0_0000;
            fl  = (!na && !nb) ? 5'b10000 : 5'b00000;
        end else if (ia || ib) begin
            res = {s, 8'hFF, 23'd0};
            fl  = 5'b00000;
        end else if (za || zb) begin
            res = {s, 31'd0};
            fl  = 5'b00001;
        end else begin
            p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            k = 0;
            for (int i = 0; i < 48; i++) if (p[i]) k = i;
            sh   = k - 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                k = k + 1;
            end
            e = ea + eb - 127 + (k - 46);
            if (e >= 255) begin
                res = {s, 8'hFF, 23'd0};
                fl  = 5'b01010;
            end else if (e <= 0) begin
                res = {s, 31'd0};
                fl  = 5'b00111;
            end else begin
                res = {s, 8'(e), q[22:0]};
                fl  = {3'b000, rem != 0, 1'b0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: e = 8'h00;
            1: begin e = 8'hFF; f = '0; end
            2: begin e = 8'hFF; f = f | 23'd1; end
            3: e = 8'($urandom_range(200, 254));
            4: e = 8'($urandom_range(1, 60));
            5: begin e = 8'($urandom_range(100, 150)); f = f | 23'h7FFF00; end
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {s, e, f};
    endfunction

    // Scoreboard: push on accepted input, compare the head whenever a result is shown.
    logic [31:0] sb_r;
    logic [4:0]  sb_f;
    exp_t        sb_e;
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    check("sb_result", 64'(bus.out_result), 64'(sb_q[0].r));
                    check("sb_tag",    64'(bus.out_tag),    64'(sb_q[0].t));
                    check("sb_flags",  64'(bus.out_flags),  64'(sb_q[0].f));
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                ref_mul(bus.in_a, bus.in_b, sb_r, sb_f);
                sb_e.r = sb_r;
                sb_e.t = bus.in_tag;
                sb_e.f = sb_f;
                sb_q.push_back(sb_e);
            end
        end
    end

    task automatic run_directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag, input logic [31:0] er, input logic [4:0] ef);
        int n;
        logic [31:0] mr;
        logic [4:0]  mf;
        ref_mul(a, b, mr, mf);
        check({nm, "_model_res"},   64'(mr), 64'(er));
        check({nm, "_model_flags"}, 64'(mf), 64'(ef));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        @(negedge clk);
        check({nm, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (n < 8 && !bus.out_valid) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 64'(n),              64'(3));
        check({nm, "_result"},  64'(bus.out_result), 64'(er));
        check({nm, "_flags"},   64'(bus.out_flags),  64'(ef));
        check({nm, "_tag"},     64'(bus.out_tag),    64'(tag));
    endtask

    logic [31:0] dir_a  [10] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'hFF800000, 32'h00800000,
                                 32'h00400000, 32'h3F842108, 32'h7F800001, 32'hFF800000, 32'h80000000};
    logic [31:0] dir_b  [10] = '{32'h40000000, 32'h3FC00000, 32'h7F000000, 32'h00000000, 32'h3F000000,
                                 32'h40000000, 32'h3FF80000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] dir_r  [10] = '{32'h40400000, 32'h3FC00002, 32'h7F800000, 32'h7FC00000, 32'h00000000,
                                 32'h00000000, 32'h40000000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    logic [4:0]  dir_f  [10] = '{5'b00000, 5'b00010, 5'b01010, 5'b10000, 5'b00111,
                                 5'b00001, 5'b00010, 5'b00000, 5'b00000, 5'b00001};

    logic        bp_ov [12];
    logic        bp_ir [12];
    logic [3:0]  bp_tg [12];
    logic [31:0] bp_rs [12];

    initial begin
        int idx;
        int acc_early;
        bit pending;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid",  64'(bus.out_valid),  64'(0));
        check("rst_out_result", 64'(bus.out_result), 64'(0));
        check("rst_out_tag",    64'(bus.out_tag),    64'(0));
        check("rst_out_flags",  64'(bus.out_flags),  64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < 10; i++)
            run_directed($sformatf("dir%0d", i), dir_a[i], dir_b[i], 4'(i + 1), dir_r[i], dir_f[i]);

        // Backpressure: five tagged ops with the consumer stalled for six cycles.
        idx = 0;
        acc_early = 0;
        bus.in_a = rand_op();
        bus.in_b = rand_op();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            bus.out_ready = (k >= 6);
            bus.in_valid  = (idx < 5);
            bus.in_tag    = 4'(idx + 1);
            @(negedge clk);
            bp_ov[k] = bus.out_valid;
            bp_ir[k] = bus.in_ready;
            bp_tg[k] = bus.out_tag;
            bp_rs[k] = bus.out_result;
            if (bus.in_valid && bus.in_ready) begin
                idx++;
                bus.in_a = rand_op();
                bus.in_b = rand_op();
            end
            if (k == 5) acc_early = idx;
        end
        bus.in_valid = 1'b0;
        check("bp_accepts_stalled", 64'(acc_early), 64'(3));
        check("bp_in_ready_low",    64'(bp_ir[5]),  64'(0));
        check("bp_first_tag",       64'(bp_tg[3]),  64'(1));
        check("bp_hold_result",     64'(bp_rs[5]),  64'(bp_rs[3]));
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp_drain_valid%0d", j), 64'(bp_ov[6 + j]), 64'(1));
            check($sformatf("bp_drain_tag%0d", j),   64'(bp_tg[6 + j]), 64'(j + 1));
        end

        // Reset with two operations in flight.
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = rand_op();
        bus.in_b      = rand_op();
        bus.in_tag    = 4'd6;
        @(posedge clk); #1;
        bus.in_a      = rand_op();
        bus.in_tag    = 4'd7;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid_before", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_valid",  64'(bus.out_valid),  64'(0));
        check("mid_rst_result", 64'(bus.out_result), 64'(0));
        check("mid_rst_flags",  64'(bus.out_flags),  64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("post_rst_no_stale", 64'(bus.out_valid), 64'(0));
        end
        run_directed("post_rst", 32'h3FC00000, 32'h40000000, 4'd9, 32'h40400000, 5'b00000);

        // Randomised traffic with random backpressure.
        pending = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 9) < 7) begin
                bus.in_a   = rand_op();
                bus.in_b   = rand_op();
                bus.in_tag = 4'($urandom);
                pending    = 1'b1;
            end
            bus.in_valid = pending;
            @(negedge clk);
            if (pending && bus.in_ready) pending = 1'b0;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (n < 20 && sb_q.size() != 0) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Pipelined, parametrised IEEE-754 binary floating-point multiplier with valid/ready handshake on both sides. It is the clocked successor to the team's combinational single-precision multiplier.
- Adds:
  - configurable exponent/mantissa widths;
  - full special-value handling (NaN/Inf/zero);
  - round-to-nearest-even with mantissa-carry exponent adjust;
  - a sticky-free per-result exception flag set;
  - a sideband tag that travels with each operation.
- Sits between the ALU operand-issue logic and the result writeback arbiter.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit excluded).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. Asynchronous and active-high: assertion clears state immediately; release is synchronised externally.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- in_a  in  1+EXP_W+MAN_W  operand A, {sign, exp, frac}.
- in_b  in  1+EXP_W+MAN_W  operand B.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  1+EXP_W+MAN_W  packed product.
- out_tag  out  TAG_W  tag of the same operation.
- out_flags  out  5  {invalid, overflow, underflow, inexact, zero_res}.

Behaviour:
- Reset: all stage valids = 0; out_valid = 0, out_result = 0, out_tag = 0, out_flags = 0. in_ready = 1 once reset is released. Reset mid-operation discards all in-flight operations and produces no partial output.
- Pipeline has three stages with fixed latency of 3 cycles from handshake (in_valid & in_ready) to out_valid, assuming no stalls.
  - S1: unpack/classify, XOR signs, compute exponent sum minus bias (width EXP_W+2, signed).
  - S2: (MAN_W+1)x(MAN_W+1) mantissa product.
  - S3: normalise, round, pack, flags.
- Flow control: advance = !out_valid | out_ready; in_ready = advance. This is a global stall: when the output is held, every stage holds, so there are no bubbles and no reordering. Maximum occupancy is 3.
- Bubbles: an empty stage is overwritten when advance = 1. Throughput is one result per cycle while out_ready = 1.
- Holding rule: out_result, out_tag and out_flags stay stable while out_valid & !out_ready.
- Input classes:
  - exp = 0: zero. Subnormal inputs are treated as signed zero (DAZ); fraction is ignored.
  - exp all-ones with frac != 0: NaN.
  - exp all-ones with frac = 0: Inf.
- Special-value priority, highest first:
  - any NaN, or Inf x 0: canonical quiet NaN {0, all-ones, 1, 0...}. invalid = 1 for Inf x 0 only.
  - Inf x nonzero finite or Inf: signed Inf, no flags.
  - zero x finite: signed zero, zero_res = 1.
- Normal path:
  - Product bit 2*MAN_W+1 set: take the upper fraction and add 1 to the exponent. Otherwise shift left by 1.
  - Rounding is RNE: round_up = G & (R | S | LSB).
  - If rounding carries out of the fraction (fraction all-ones + 1), the fraction becomes 0 and the exponent is incremented. The overflow check is applied after this increment.
- Overflow: biased result exponent >= all-ones produces signed Inf with overflow = 1 and inexact = 1.
- Underflow: biased result exponent <= 0 produces signed zero (FTZ) with underflow = 1, inexact = 1 and zero_res = 1.
- inexact = G | R | S on the normal path. zero_res = 1 whenever the packed magnitude is zero.

Decomposition:
- Package fp_pkg holds:
  - bias, all-ones exponent and canonical-NaN constants as functions of EXP_W/MAN_W;
  - the flag bit indices;
  - the class enum {ZERO, NORM, INF, NAN}.
- Sub-module fp_unpack: classify plus hidden-bit insert for one operand, instantiated twice in S1. It is reused later by the adder.

Test Plan:
- 0x3FC00000 x 0x40000000 (1.5 x 2.0), out_ready = 1 → 0x40400000 exactly 3 cycles after the handshake; flags = 0.
- 0x3F800001 x 0x3FC00000 → tie with odd LSB rounds up to 0x3FC00002; inexact = 1.
- 0x7F000000 x 0x7F000000 → 0x7F800000; overflow = 1, inexact = 1. 0xFF800000 x 0x00000000 → 0x7FC00000; invalid = 1.
- 0x00800000 x 0x3F000000 → 0x00000000; underflow = 1, inexact = 1, zero_res = 1. 0x00400000 (subnormal) x 0x40000000 → 0x00000000; zero_res = 1.
- Backpressure: issue 5 ops with tags 1..5 and out_ready = 0.
  - in_ready falls after 3 accepts and out_result holds stable.
  - Release out_ready: tags emerge 1..5 in order, back-to-back.
- Reset: assert rst with 2 ops in flight → out_valid = 0 immediately and no stale result after release; the next op emerges with the correct 3-cycle latency.
